// File: rtl/e203_exu_flush_arb.sv
// -----------------------------------------------------------------------------
// e203_exu_flush_arb
//
// Shares the single IFU pipe-flush port among N_REQ flush requesters.
// Requester 0 has the highest priority (excp/irq), followed by
// branch-mispredict, fence.i and debug. A request reaches the IFU in the
// cycle it arrives. If the IFU does not accept it at once, the winner is
// locked until the IFU acks. Each completed flush can be followed by a quiet
// gap of GAP_CYC cycles before the next flush is offered.
//
// Parameters
//   N_REQ    number of flush requesters (2..8)
//   PC_SIZE  width of the flush-adder operands
//   GAP_CYC  idle cycles forced after each completed flush (0..15)
//
// Ports
//   clk          core clock
//   rst_n        async active-low reset
//   req_valid    per-requester flush request
//   req_op1      packed flush-adder op1, slice i belongs to requester i
//   req_op2      packed flush-adder op2, slice i belongs to requester i
//   req_ack      one-hot pulse: the flush of requester i was accepted
//   flush_req    flush request to the IFU
//   flush_op1    op1 of the current winner (live mux, never registered)
//   flush_op2    op2 of the current winner (live mux, never registered)
//   flush_ack    IFU accepts the flush
//   flush_pulse  flush_req & flush_ack
//   flush_src    one-hot current winner, zero when flush_req is low
//   busy         arbiter is in LOCK or GAP
//   proto_err    sticky: a locked requester dropped req_valid before its ack
//   flush_cnt    completed flushes, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module e203_exu_flush_arb #(
   parameter int N_REQ   = 3,
   parameter int PC_SIZE = 32,
   parameter int GAP_CYC = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*PC_SIZE-1:0] req_op1,
   input  logic [N_REQ*PC_SIZE-1:0] req_op2,
   output logic [N_REQ-1:0]         req_ack,
   output logic                     flush_req,
   output logic [PC_SIZE-1:0]       flush_op1,
   output logic [PC_SIZE-1:0]       flush_op2,
   input  logic                     flush_ack,
   output logic                     flush_pulse,
   output logic [N_REQ-1:0]         flush_src,
   output logic                     busy,
   output logic                     proto_err,
   output logic [15:0]              flush_cnt
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Value loaded into the gap counter when GAP is entered; GAP is left
   // once the counter reads zero, giving GAP_CYC idle cycles in total.
   localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;
   localparam bit         HAS_GAP  = (GAP_CYC > 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOCK = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] lock_idx;
   logic [3:0]       gap_cnt;
   logic             proto_err_q;
   logic [15:0]      flush_cnt_q;

   logic [IDX_W-1:0] pri_idx;
   logic [N_REQ-1:0] pri_oh;
   logic [N_REQ-1:0] lock_oh;
   logic [N_REQ-1:0] cur_oh;
   logic             any_req;
   logic             lock_valid;
   logic             req_live;
   logic             pulse;

   // ---------------------------------------------------------------------------
   // Fixed-priority pick: lowest set index wins. The loop runs from the top
   // down so the last assignment belongs to the lowest requesting index.
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      pri_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            pri_idx = IDX_W'(i);
         end
      end
   end

   // One-hot decodes of the fresh winner and of the locked index. Decoding
   // by comparison keeps every access inside 0..N_REQ-1 even when N_REQ is
   // not a power of two.
   always_comb begin
      pri_oh  = '0;
      lock_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pri_idx == IDX_W'(i)) begin
            pri_oh[i] = 1'b1;
         end
         if (lock_idx == IDX_W'(i)) begin
            lock_oh[i] = 1'b1;
         end
      end
   end

   assign any_req    = |req_valid;
   assign lock_valid = |(req_valid & lock_oh);

   // While LOCKed only the registered winner is visible; newer requests,
   // even higher-priority ones, wait for the ack.
   always_comb begin
      cur_oh   = pri_oh;
      req_live = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cur_oh   = pri_oh;
            req_live = any_req;
         end
         ST_LOCK: begin
            cur_oh   = lock_oh;
            req_live = lock_valid;
         end
         ST_GAP: begin
            cur_oh   = pri_oh;
            req_live = 1'b0;
         end
         default: begin
            cur_oh   = pri_oh;
            req_live = 1'b0;
         end
      endcase
   end

   // The request path is combinational from req_valid, so it is also gated
   // by rst_n: every output reads zero while reset is held, even if the
   // requesters keep their lines up.
   assign flush_req   = req_live & rst_n;
   assign pulse       = flush_req & flush_ack;
   assign flush_pulse = pulse;
   assign flush_src   = flush_req ? cur_oh : '0;
   assign req_ack     = pulse ? cur_oh : '0;

   // AND-OR operand mux on the live requester operands. flush_src is
   // one-hot or zero, so at most one slice contributes.
   always_comb begin
      flush_op1 = '0;
      flush_op2 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (flush_src[i]) begin
            flush_op1 = flush_op1 | req_op1[i*PC_SIZE +: PC_SIZE];
            flush_op2 = flush_op2 | req_op2[i*PC_SIZE +: PC_SIZE];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Arbitration FSM
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so that
   // every register samples the values from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         lock_idx    <= '0;
         gap_cnt     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (pulse) begin
                  if (HAS_GAP) begin
                     state   <= ST_GAP;
                     gap_cnt <= GAP_LOAD;
                  end else begin
                     state   <= ST_IDLE;
                  end
               end else if (any_req) begin
                  state    <= ST_LOCK;
                  lock_idx <= pri_idx;
               end
            end
            ST_LOCK: begin
               if (!lock_valid) begin
                  // The locked requester withdrew before its ack. The grant
                  // is dropped without an ack and the violation is latched.
                  state       <= ST_IDLE;
                  proto_err_q <= 1'b1;
               end else if (pulse) begin
                  if (HAS_GAP) begin
                     state   <= ST_GAP;
                     gap_cnt <= GAP_LOAD;
                  end else begin
                     state   <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == 4'd0) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Completed-flush counter, saturating so it never wraps back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt_q <= 16'd0;
      end else if (pulse && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign proto_err = proto_err_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// -----------------------------------------------------------------------------
// Testbench for e203_exu_flush_arb.
// Two instances share clk/rst_n: dut (GAP_CYC=1) for the scenario tests and
// dut0 (GAP_CYC=0) for back-to-back flushes and counter saturation.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising edge.
// -----------------------------------------------------------------------------
module tb_e203_exu_flush_arb;

   localparam int N  = 3;
   localparam int PW = 32;

   logic          clk;
   logic          rst_n;

   logic [N-1:0]    req_valid;
   logic [N*PW-1:0] req_op1;
   logic [N*PW-1:0] req_op2;
   logic [N-1:0]    req_ack;
   logic            flush_req;
   logic [PW-1:0]   flush_op1;
   logic [PW-1:0]   flush_op2;
   logic            flush_ack;
   logic            flush_pulse;
   logic [N-1:0]    flush_src;
   logic            busy;
   logic            proto_err;
   logic [15:0]     flush_cnt;

   logic [N-1:0]    req_valid0;
   logic [N*PW-1:0] req_op1_0;
   logic [N*PW-1:0] req_op2_0;
   logic [N-1:0]    req_ack0;
   logic            flush_req0;
   logic [PW-1:0]   flush_op1_0;
   logic [PW-1:0]   flush_op2_0;
   logic            flush_ack0;
   logic            flush_pulse0;
   logic [N-1:0]    flush_src0;
   logic            busy0;
   logic            proto_err0;
   logic [15:0]     flush_cnt0;

   int total;
   int bad;
   logic [15:0] exp_cnt;

   e203_exu_flush_arb #(.N_REQ(N), .PC_SIZE(PW), .GAP_CYC(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_op1     (req_op1),
      .req_op2     (req_op2),
      .req_ack     (req_ack),
      .flush_req   (flush_req),
      .flush_op1   (flush_op1),
      .flush_op2   (flush_op2),
      .flush_ack   (flush_ack),
      .flush_pulse (flush_pulse),
      .flush_src   (flush_src),
      .busy        (busy),
      .proto_err   (proto_err),
      .flush_cnt   (flush_cnt)
   );

   e203_exu_flush_arb #(.N_REQ(N), .PC_SIZE(PW), .GAP_CYC(0)) dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid0),
      .req_op1     (req_op1_0),
      .req_op2     (req_op2_0),
      .req_ack     (req_ack0),
      .flush_req   (flush_req0),
      .flush_op1   (flush_op1_0),
      .flush_op2   (flush_op2_0),
      .flush_ack   (flush_ack0),
      .flush_pulse (flush_pulse0),
      .flush_src   (flush_src0),
      .busy        (busy0),
      .proto_err   (proto_err0),
      .flush_cnt   (flush_cnt0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Move to the next sample point: falling edge, then settle.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      req_op1    = '0;
      req_op2    = '0;
      flush_ack  = 1'b0;
      req_valid0 = '0;
      req_op1_0  = '0;
      req_op2_0  = '0;
      flush_ack0 = 1'b0;
      exp_cnt    = 16'd0;
      repeat (2) next_cycle();
      #1;
      total++; if (flush_req !== 1'b0) begin bad++; $display("FAIL reset_flush_req got=%b want=0", flush_req); end
      total++; if (req_ack !== 3'b000) begin bad++; $display("FAIL reset_req_ack got=%b want=000", req_ack); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%b want=0", proto_err); end
      total++; if (flush_cnt !== 16'd0) begin bad++; $display("FAIL reset_flush_cnt got=%h want=0000", flush_cnt); end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   // T1: single request acked in its arrival cycle, followed by one GAP cycle.
   task automatic test_single();
      next_cycle();
      req_valid        = 3'b010;
      req_op1[PW +: PW] = 32'h8000_0000;
      req_op2[PW +: PW] = 32'h0000_0004;
      flush_ack        = 1'b1;
      #1;
      total++; if (flush_req !== 1'b1) begin bad++; $display("FAIL t1_flush_req got=%b want=1", flush_req); end
      total++; if (flush_op1 !== 32'h8000_0000) begin bad++; $display("FAIL t1_flush_op1 got=%h want=80000000", flush_op1); end
      total++; if (flush_op2 !== 32'h0000_0004) begin bad++; $display("FAIL t1_flush_op2 got=%h want=00000004", flush_op2); end
      total++; if (req_ack !== 3'b010) begin bad++; $display("FAIL t1_req_ack got=%b want=010", req_ack); end
      total++; if (flush_src !== 3'b010) begin bad++; $display("FAIL t1_flush_src got=%b want=010", flush_src); end
      total++; if (flush_pulse !== 1'b1) begin bad++; $display("FAIL t1_flush_pulse got=%b want=1", flush_pulse); end
      exp_cnt = exp_cnt + 16'd1;
      next_cycle();
      req_valid = 3'b000;
      flush_ack = 1'b0;
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_gap_busy got=%b want=1", busy); end
      total++; if (flush_req !== 1'b0) begin bad++; $display("FAIL t1_gap_flush_req got=%b want=0", flush_req); end
      total++; if (flush_cnt !== exp_cnt) begin bad++; $display("FAIL t1_flush_cnt got=%h want=%h", flush_cnt, exp_cnt); end
      next_cycle();
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_idle_busy got=%b want=0", busy); end
   endtask

   // T2: requester 1 locked; requester 0 arrives later and must wait.
   task automatic test_lock();
      next_cycle();
      req_valid         = 3'b010;
      req_op1[PW +: PW] = 32'h0000_0100;
      req_op1[0 +: PW]  = 32'h0000_0200;
      flush_ack         = 1'b0;
      #1;
      total++; if (flush_src !== 3'b010) begin bad++; $display("FAIL t2_c1_src got=%b want=010", flush_src); end
      total++; if (req_ack !== 3'b000) begin bad++; $display("FAIL t2_c1_req_ack got=%b want=000", req_ack); end
      next_cycle();
      req_valid = 3'b011;
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t2_lock_busy got=%b want=1", busy); end
      total++; if (flush_src !== 3'b010) begin bad++; $display("FAIL t2_c2_src got=%b want=010", flush_src); end
      total++; if (flush_op1 !== 32'h0000_0100) begin bad++; $display("FAIL t2_c2_op1 got=%h want=00000100", flush_op1); end
      next_cycle();
      #1;
      total++; if (flush_src !== 3'b010) begin bad++; $display("FAIL t2_c3_src got=%b want=010", flush_src); end
      total++; if (flush_req !== 1'b1) begin bad++; $display("FAIL t2_c3_flush_req got=%b want=1", flush_req); end
      next_cycle();
      flush_ack = 1'b1;
      #1;
      total++; if (req_ack !== 3'b010) begin bad++; $display("FAIL t2_ack1 got=%b want=010", req_ack); end
      exp_cnt = exp_cnt + 16'd1;
      next_cycle();
      req_valid = 3'b001;
      #1;
      total++; if (flush_req !== 1'b0) begin bad++; $display("FAIL t2_gap_flush_req got=%b want=0", flush_req); end
      total++; if (req_ack !== 3'b000) begin bad++; $display("FAIL t2_gap_req_ack got=%b want=000", req_ack); end
      next_cycle();
      #1;
      total++; if (flush_src !== 3'b001) begin bad++; $display("FAIL t2_src0 got=%b want=001", flush_src); end
      total++; if (flush_op1 !== 32'h0000_0200) begin bad++; $display("FAIL t2_op1_0 got=%h want=00000200", flush_op1); end
      total++; if (req_ack !== 3'b001) begin bad++; $display("FAIL t2_ack0 got=%b want=001", req_ack); end
      exp_cnt = exp_cnt + 16'd1;
      next_cycle();
      req_valid = 3'b000;
      flush_ack = 1'b0;
      #1;
      total++; if (flush_cnt !== exp_cnt) begin bad++; $display("FAIL t2_flush_cnt got=%h want=%h", flush_cnt, exp_cnt); end
      next_cycle();
   endtask

   // T3: all three requesters at once, ack always high; grants in index order
   // with one idle cycle between them.
   task automatic test_simultaneous();
      logic [N-1:0] want_ack;
      logic [N-1:0] pending;
      next_cycle();
      for (int k = 0; k < N; k++) begin
         req_op1[k*PW +: PW] = 32'h1000_0000 + 32'(k);
         req_op2[k*PW +: PW] = 32'h2000_0000 + 32'(k);
      end
      pending   = 3'b111;
      req_valid = pending;
      flush_ack = 1'b1;
      for (int k = 0; k < N; k++) begin
         want_ack = 3'b001 << k;
         #1;
         total++; if (req_ack !== want_ack) begin bad++; $display("FAIL t3_grant%0d got=%b want=%b", k, req_ack, want_ack); end
         total++; if (flush_op1 !== 32'h1000_0000 + 32'(k)) begin bad++; $display("FAIL t3_op1_%0d got=%h want=%h", k, flush_op1, 32'h1000_0000 + 32'(k)); end
         total++; if (flush_op2 !== 32'h2000_0000 + 32'(k)) begin bad++; $display("FAIL t3_op2_%0d got=%h want=%h", k, flush_op2, 32'h2000_0000 + 32'(k)); end
         exp_cnt = exp_cnt + 16'd1;
         next_cycle();
         pending   = pending & ~want_ack;
         req_valid = pending;
         #1;
         total++; if (flush_req !== 1'b0) begin bad++; $display("FAIL t3_gap%0d got=%b want=0", k, flush_req); end
         next_cycle();
      end
      flush_ack = 1'b0;
      #1;
      total++; if (flush_cnt !== exp_cnt) begin bad++; $display("FAIL t3_flush_cnt got=%h want=%h", flush_cnt, exp_cnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_end_busy got=%b want=0", busy); end
   endtask

   // T4: locked requester 2 withdraws before its ack.
   task automatic test_proto_err();
      next_cycle();
      req_valid = 3'b100;
      flush_ack = 1'b0;
      #1;
      total++; if (flush_src !== 3'b100) begin bad++; $display("FAIL t4_src got=%b want=100", flush_src); end
      next_cycle();
      req_valid = 3'b000;
      flush_ack = 1'b1;
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_lock_busy got=%b want=1", busy); end
      total++; if (flush_req !== 1'b0) begin bad++; $display("FAIL t4_drop_flush_req got=%b want=0", flush_req); end
      total++; if (req_ack !== 3'b000) begin bad++; $display("FAIL t4_drop_req_ack got=%b want=000", req_ack); end
      total++; if (flush_pulse !== 1'b0) begin bad++; $display("FAIL t4_drop_pulse got=%b want=0", flush_pulse); end
      next_cycle();
      flush_ack = 1'b0;
      #1;
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL t4_proto_err got=%b want=1", proto_err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_idle got=%b want=0", busy); end
      total++; if (flush_cnt !== exp_cnt) begin bad++; $display("FAIL t4_flush_cnt got=%h want=%h", flush_cnt, exp_cnt); end
      repeat (2) next_cycle();
      #1;
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL t4_sticky got=%b want=1", proto_err); end
   endtask

   // T5: reset asserted while LOCKed; the held request is re-issued at once
   // after release.
   task automatic test_reset_mid_lock();
      next_cycle();
      req_valid        = 3'b001;
      req_op1[0 +: PW] = 32'h0000_0ABC;
      flush_ack        = 1'b0;
      next_cycle();
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_lock got=%b want=1", busy); end
      rst_n = 1'b0;
      #1;
      total++; if (flush_req !== 1'b0) begin bad++; $display("FAIL t5_rst_flush_req got=%b want=0", flush_req); end
      total++; if (flush_src !== 3'b000) begin bad++; $display("FAIL t5_rst_src got=%b want=000", flush_src); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_rst_busy got=%b want=0", busy); end
      total++; if (flush_cnt !== 16'd0) begin bad++; $display("FAIL t5_rst_cnt got=%h want=0000", flush_cnt); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL t5_rst_proto_err got=%b want=0", proto_err); end
      total++; if (flush_op1 !== 32'd0) begin bad++; $display("FAIL t5_rst_op1 got=%h want=00000000", flush_op1); end
      exp_cnt = 16'd0;
      next_cycle();
      rst_n = 1'b1;
      #1;
      total++; if (flush_src !== 3'b001) begin bad++; $display("FAIL t5_reissue_src got=%b want=001", flush_src); end
      total++; if (flush_op1 !== 32'h0000_0ABC) begin bad++; $display("FAIL t5_reissue_op1 got=%h want=00000abc", flush_op1); end
      next_cycle();
      flush_ack = 1'b1;
      #1;
      total++; if (req_ack !== 3'b001) begin bad++; $display("FAIL t5_ack got=%b want=001", req_ack); end
      exp_cnt = exp_cnt + 16'd1;
      next_cycle();
      req_valid = 3'b000;
      flush_ack = 1'b0;
      #1;
      total++; if (flush_cnt !== exp_cnt) begin bad++; $display("FAIL t5_flush_cnt got=%h want=%h", flush_cnt, exp_cnt); end
      next_cycle();
   endtask

   // T6: GAP_CYC=0 instance, one acked flush per cycle, counter saturates.
   task automatic test_saturation();
      next_cycle();
      req_valid0         = 3'b001;
      req_op1_0[0 +: PW] = 32'h0000_0040;
      flush_ack0         = 1'b1;
      #1;
      total++; if (req_ack0 !== 3'b001) begin bad++; $display("FAIL t6_req_ack got=%b want=001", req_ack0); end
      repeat (65534) next_cycle();
      #1;
      total++; if (flush_cnt0 !== 16'hFFFE) begin bad++; $display("FAIL t6_cnt_fffe got=%h want=fffe", flush_cnt0); end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL t6_no_gap got=%b want=0", busy0); end
      next_cycle();
      #1;
      total++; if (flush_cnt0 !== 16'hFFFF) begin bad++; $display("FAIL t6_cnt_ffff got=%h want=ffff", flush_cnt0); end
      repeat (5) next_cycle();
      #1;
      total++; if (flush_cnt0 !== 16'hFFFF) begin bad++; $display("FAIL t6_cnt_sat got=%h want=ffff", flush_cnt0); end
      req_valid0 = 3'b000;
      flush_ack0 = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_lock();
      test_simultaneous();
      test_proto_err();
      test_reset_mid_lock();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
